spice_node_integrator: RTL and testbench



---
 rtl/spice_node_integrator_pkg.sv | 18 +
 rtl/spice_node_clamp.sv | 32 +++
 rtl/spice_node_integrator.sv | 133 +++++++++++++
 tb/tb_spice_node_integrator.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spice_node_integrator_pkg.sv
// Shared types and constants for the node-voltage integrator.
//   W       : node voltage / terminal current width
//   HI, LO  : clamp window for the node voltage
//   node_state_e : integrator FSM states
package spice_node_integrator_pkg;

    localparam int unsigned W = 16;

    localparam logic signed [W-1:0] HI = 16'sh2000;
    localparam logic signed [W-1:0] LO = 16'shE000;

    typedef enum logic [1:0] {
        StIdle,
        StSum,
        StUpdate
    } node_state_e;

endpackage

// File: rtl/spice_node_clamp.sv
// Combinational clamp of a wide signed value into the node voltage window [LO, HI].
// Ports:
//   val_i     : signed input, IW bits (IW > W)
//   res_o     : W-bit signed result, clamped to [LO, HI]
//   clamped_o : high when the input lay outside the window
module spice_node_clamp
    import spice_node_integrator_pkg::*;
#(
    parameter int unsigned IW = 24
) (
    input  logic signed [IW-1:0] val_i,
    output logic signed [W-1:0]  res_o,
    output logic                 clamped_o
);

    // Window limits sign-extended to the input width so the compares are exact.
    localparam logic signed [IW-1:0] HiExt = IW'(HI);
    localparam logic signed [IW-1:0] LoExt = IW'(LO);

    always_comb begin
        res_o     = val_i[W-1:0];
        clamped_o = 1'b0;
        if (val_i > HiExt) begin
            res_o     = HI;
            clamped_o = 1'b1;
        end else if (val_i < LoExt) begin
            res_o     = LO;
            clamped_o = 1'b1;
        end
    end

endmodule

// File: rtl/spice_node_integrator.sv
// Sequential node-voltage integrator. On step_i it serially sums the N terminal
// currents, then integrates (sum >>> SHIFT) into the node voltage with clamping.
// Ports:
//   clk_i      : clock
//   reset_i    : synchronous, active-high reset
//   i_flat_i   : N signed terminal currents, terminal k at [k*W +: W]
//   step_i     : start one integration step (ignored unless idle)
//   busy_o     : a step is in progress
//   done_o     : one-cycle pulse when the new v_o is valid
//   v_o        : node voltage, signed
//   sat_o      : last update was clamped
//   settled_o  : SETTLE_CNT consecutive quiet steps have occurred
module spice_node_integrator
    import spice_node_integrator_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned SHIFT      = 2,
    parameter int unsigned SETTLE_TH  = 4,
    parameter int unsigned SETTLE_CNT = 3,
    parameter int          INIT       = 0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [N*W-1:0]      i_flat_i,
    input  logic                step_i,
    output logic                busy_o,
    output logic                done_o,
    output logic signed [W-1:0] v_o,
    output logic                sat_o,
    output logic                settled_o
);

    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW = W + $clog2(N) + 1;
    // One extra bit so v + shifted sum never wraps before clamping.
    localparam int unsigned NW = AW + 1;
    localparam int unsigned CW = (SETTLE_CNT > 0) ? $clog2(SETTLE_CNT + 1) : 1;

    node_state_e          state_q;
    logic [KW-1:0]        k_q;
    logic signed [AW-1:0] acc_q;
    logic signed [W-1:0]  v_q;
    logic                 sat_q;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q;
    logic                 done_q;

    logic signed [W-1:0]  term;
    logic signed [AW-1:0] term_ext;
    logic signed [AW-1:0] acc_shift;
    logic signed [NW-1:0] nv;
    logic [AW-1:0]        acc_abs;
    logic                 quiet;
    logic [CW-1:0]        cnt_d;
    logic signed [W-1:0]  v_d;
    logic                 sat_d;

    always_comb begin
        term      = i_flat_i[int'(k_q)*W +: W];
        term_ext  = AW'(term);
        // Arithmetic shift rounds toward -inf.
        acc_shift = acc_q >>> SHIFT;
        nv        = NW'(v_q) + NW'(acc_shift);
        // acc never reaches its most negative value, so negation cannot overflow.
        acc_abs   = acc_q[AW-1] ? AW'(-acc_q) : AW'(acc_q);
        quiet     = (acc_abs <= AW'(SETTLE_TH));
        if (!quiet) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(SETTLE_CNT)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    spice_node_clamp #(
        .IW (NW)
    ) u_clamp (
        .val_i     (nv),
        .res_o     (v_d),
        .clamped_o (sat_d)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            k_q     <= '0;
            acc_q   <= '0;
            v_q     <= W'(INIT);
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (step_i) begin
                        state_q <= StSum;
                        busy_q  <= 1'b1;
                        acc_q   <= '0;
                        k_q     <= '0;
                    end
                end
                StSum: begin
                    acc_q <= acc_q + term_ext;
                    if (k_q == KW'(N - 1)) begin
                        k_q     <= '0;
                        state_q <= StUpdate;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                StUpdate: begin
                    v_q     <= v_d;
                    sat_q   <= sat_d;
                    cnt_q   <= cnt_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign v_o       = v_q;
    assign sat_o     = sat_q;
    assign settled_o = (cnt_q == CW'(SETTLE_CNT));

endmodule

// File: tb/tb_spice_node_integrator.sv
// Bench for spice_node_integrator (W=16, N=4, SHIFT=2, SETTLE_TH=4, SETTLE_CNT=3, INIT=0).
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
module tb_spice_node_integrator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] i_flat = '0;
    logic        step = 1'b0;
    logic        busy;
    logic        done;
    logic signed [15:0] v;
    logic        sat;
    logic        settled;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_v   = 0;
    int m_sat = 0;
    int m_cnt = 0;
    int m_sum = 0;

    always #5 clk = ~clk;

    spice_node_integrator #(
        .N          (4),
        .SHIFT      (2),
        .SETTLE_TH  (4),
        .SETTLE_CNT (3),
        .INIT       (0)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .i_flat_i  (i_flat),
        .step_i    (step),
        .busy_o    (busy),
        .done_o    (done),
        .v_o       (v),
        .sat_o     (sat),
        .settled_o (settled)
    );

    task automatic model_reset();
        m_v   = 0;
        m_sat = 0;
        m_cnt = 0;
    endtask

    // One integration step: v += floor(sum / 4), clamp to [-8192, 8192].
    task automatic model_step();
        int q;
        int nv;
        int a;
        q = m_sum / 4;
        if (m_sum < 0 && q * 4 != m_sum) q = q - 1;
        nv = m_v + q;
        if (nv > 8192) begin
            m_v = 8192; m_sat = 1;
        end else if (nv < -8192) begin
            m_v = -8192; m_sat = 1;
        end else begin
            m_v = nv; m_sat = 0;
        end
        a = (m_sum < 0) ? -m_sum : m_sum;
        if (a <= 4) m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
        else        m_cnt = 0;
    endtask

    task automatic apply_cur(input int c0, input int c1, input int c2, input int c3);
        i_flat = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
        m_sum  = c0 + c1 + c2 + c3;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Pulses step for one edge, returns edges from acceptance to done (-1 on timeout).
    task automatic run_step(output int lat, output logic busy_at_done);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        lat = -1;
        busy_at_done = 1'bx;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = e;
                busy_at_done = busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (v !== 16'sd0) begin errors++; $display("FAIL reset_v got=%0d exp=0", v); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%b exp=0", sat); end
        checks++;
        if (settled !== 1'b0) begin
            errors++; $display("FAIL reset_settled got=%b exp=0", settled);
        end
    endtask

    task automatic test_zero_steps();
        int lat;
        logic bd;
        apply_cur(0, 0, 0, 0);
        for (int s = 1; s <= 3; s++) begin
            run_step(lat, bd);
            model_step();
            checks++;
            if (lat !== 5) begin errors++; $display("FAIL zero_latency s=%0d got=%0d exp=5", s, lat); end
            checks++;
            if (bd !== 1'b0) begin errors++; $display("FAIL zero_busy_at_done got=%b exp=0", bd); end
            checks++;
            if (v !== 16'(m_v)) begin errors++; $display("FAIL zero_v got=%0d exp=%0d", v, m_v); end
            checks++;
            if (settled !== (m_cnt == 3)) begin
                errors++; $display("FAIL zero_settled s=%0d got=%b exp=%b", s, settled, m_cnt == 3);
            end
        end
    endtask

    task automatic test_known();
        int lat;
        logic bd;
        apply_cur(100, 100, 100, 100);
        run_step(lat, bd);
        model_step();
        checks++; if (v !== 16'(m_v)) begin errors++; $display("FAIL known_v got=%0d exp=%0d", v, m_v); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL known_sat got=%b exp=0", sat); end
        checks++;
        if (settled !== 1'b0) begin errors++; $display("FAIL known_settled got=%b exp=0", settled); end
    endtask

    task automatic test_neg_round();
        int lat;
        logic bd;
        do_reset();
        apply_cur(-3, 0, 0, 0);
        run_step(lat, bd);
        model_step();
        checks++;
        if (v !== 16'(m_v)) begin errors++; $display("FAIL neg_round_v got=%0d exp=%0d", v, m_v); end
    endtask

    task automatic test_saturation();
        int lat;
        logic bd;
        do_reset();
        apply_cur(8176, 8176, 8176, 8176);
        run_step(lat, bd);
        model_step();
        checks++;
        if (v !== 16'(m_v)) begin errors++; $display("FAIL preload_v got=%0d exp=%0d", v, m_v); end
        apply_cur(16384, 16384, 0, 0);
        run_step(lat, bd);
        model_step();
        checks++; if (v !== 16'(m_v)) begin errors++; $display("FAIL sat_v got=%0d exp=%0d", v, m_v); end
        checks++;
        if (sat !== 1'(m_sat)) begin errors++; $display("FAIL sat_flag got=%b exp=%0d", sat, m_sat); end
        apply_cur(0, 0, 0, 0);
        run_step(lat, bd);
        model_step();
        checks++;
        if (sat !== 1'(m_sat)) begin errors++; $display("FAIL sat_clear got=%b exp=%0d", sat, m_sat); end
        checks++;
        if (v !== 16'(m_v)) begin errors++; $display("FAIL sat_hold_v got=%0d exp=%0d", v, m_v); end
    endtask

    task automatic test_random();
        int lat;
        logic bd;
        int c[4];
        do_reset();
        for (int s = 0; s < 40; s++) begin
            for (int t = 0; t < 4; t++) begin
                if ($urandom_range(0, 3) == 0) c[t] = int'($urandom_range(0, 2)) - 1;
                else                           c[t] = int'($signed(16'($urandom)));
            end
            apply_cur(c[0], c[1], c[2], c[3]);
            run_step(lat, bd);
            model_step();
            checks++;
            if (lat !== 5) begin errors++; $display("FAIL rand_latency s=%0d got=%0d exp=5", s, lat); end
            checks++;
            if (v !== 16'(m_v)) begin errors++; $display("FAIL rand_v s=%0d got=%0d exp=%0d", s, v, m_v); end
            checks++;
            if (sat !== 1'(m_sat)) begin
                errors++; $display("FAIL rand_sat s=%0d got=%b exp=%0d", s, sat, m_sat);
            end
            checks++;
            if (settled !== (m_cnt == 3)) begin
                errors++; $display("FAIL rand_settled s=%0d got=%b exp=%b", s, settled, m_cnt == 3);
            end
        end
        // A run of quiet steps must reach settled.
        apply_cur(1, -1, 1, 0);
        for (int s = 0; s < 3; s++) begin
            run_step(lat, bd);
            model_step();
        end
        checks++;
        if (settled !== (m_cnt == 3)) begin
            errors++; $display("FAIL quiet_settled got=%b exp=%b", settled, m_cnt == 3);
        end
    endtask

    task automatic test_ignore_busy();
        int nd = 0;
        apply_cur(4, 4, 4, 4);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++;
                checks++;
                if (e != 5) begin errors++; $display("FAIL ignore_done_edge got=%0d exp=5", e); end
            end
            step = (e == 2);
        end
        model_step();
        checks++; if (nd != 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", nd); end
        checks++; if (v !== 16'(m_v)) begin errors++; $display("FAIL ignore_v got=%0d exp=%0d", v, m_v); end
    endtask

    task automatic test_back_to_back();
        int nd = 0;
        apply_cur(4, 4, 4, 4);
        step = 1'b1;
        @(posedge clk); #1;
        for (int e = 1; e <= 17; e++) begin
            @(posedge clk); #1;
            if (done) begin
                checks++;
                if (e != 5 + 6 * nd) begin
                    errors++; $display("FAIL b2b_done_edge n=%0d got=%0d exp=%0d", nd, e, 5 + 6 * nd);
                end
                nd++;
                model_step();
                checks++;
                if (v !== 16'(m_v)) begin errors++; $display("FAIL b2b_v got=%0d exp=%0d", v, m_v); end
            end
            if (e == 17) step = 1'b0;
        end
        checks++; if (nd != 3) begin errors++; $display("FAIL b2b_done_count got=%0d exp=3", nd); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic bd;
        int nd = 0;
        do_reset();
        apply_cur(500, 500, 500, 500);
        run_step(lat, bd);
        model_step();
        checks++;
        if (v !== 16'(m_v)) begin errors++; $display("FAIL mid_preload_v got=%0d exp=%0d", v, m_v); end
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        checks++; if (v !== 16'(m_v)) begin errors++; $display("FAIL mid_v got=%0d exp=%0d", v, m_v); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got=%b exp=0", done); end
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL mid_late_done got=%0d exp=0", nd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_zero_steps();
        test_known();
        test_neg_round();
        test_saturation();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
